key_event_encoder: RTL and testbench

- Sits directly downstream of the keyboard matrix scanner.
- Takes the scanner's per-key samples (row index, column index, key_down), debounces each key independently and turns stable transitions into press/release event codes.
- Events are queued in a small FIFO and read out over a valid/ready handshake by the host-side logic.
- Also exports the debounced state of every key as a vector.

---
 rtl/key_event_encoder.sv | 171 +++++++++++++++++
 tb/tb_key_event_encoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder: per-key debounce of scanner samples into a press/release event FIFO.
// Build macro KEY_TIMESTAMP_EN adds a 16-bit sample timestamp to every event.
module key_event_encoder #(
   parameter int ROWS       = 4,
   parameter int COLS       = 5,
   parameter int DEB_COUNT  = 4,
   parameter int FIFO_DEPTH = 8,
`ifdef KEY_TIMESTAMP_EN
   localparam int EW        = 24
`else
   localparam int EW        = 8
`endif
) (
   input  logic          clk_50,
   input  logic          rst,
   input  logic          scan_tick,
   input  logic [2:0]    row_idx,
   input  logic [2:0]    col_idx,
   input  logic          key_down,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [EW-1:0] ev_data,
   output logic [31:0]   key_state,
   output logic          overflow
);

   localparam int NK = ROWS * COLS;
   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [5:0]  ROWS_L  = 6'(ROWS);
   localparam logic [5:0]  COLS_L  = 6'(COLS);
   localparam logic [5:0]  COLS_M  = 6'(COLS);
   localparam logic [3:0]  DEB_MAX = 4'(DEB_COUNT - 1);
   localparam logic [AW:0] FULL_C  = (AW+1)'(FIFO_DEPTH);

   logic          s1_vld_q;
   logic [2:0]    s1_row_q;
   logic [2:0]    s1_col_q;
   logic          s1_key_q;

   logic [NK-1:0] stab_q;
   logic [NK-1:0] stab_d;
   logic [3:0]    cnt_q [NK];
   logic [3:0]    cnt_d [NK];

   logic [5:0]    idx_w;
   logic [4:0]    idx;
   logic          in_rng;
   logic          push;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic [EW-1:0] ev_new;

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   occ_q;
   logic          ovf_q;

   // Stage 1: register the raw sample and its strobe
   always_ff @(posedge clk_50) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_row_q <= '0;
         s1_col_q <= '0;
         s1_key_q <= 1'b0;
      end else begin
         s1_vld_q <= scan_tick;
         if (scan_tick) begin
            s1_row_q <= row_idx;
            s1_col_q <= col_idx;
            s1_key_q <= key_down;
         end
      end
   end

   assign in_rng = s1_vld_q
                 && ({3'b000, s1_row_q} < ROWS_L)
                 && ({3'b000, s1_col_q} < COLS_L);
   assign idx_w  = {3'b000, s1_row_q} * COLS_M
                 + {3'b000, s1_col_q};
   assign idx    = idx_w[4:0];

   // Stage 2: debounce the addressed key and flag a stable transition
   always_comb begin
      stab_d = stab_q;
      cnt_d  = cnt_q;
      push   = 1'b0;
      if (in_rng) begin
         if (s1_key_q == stab_q[idx]) begin
            cnt_d[idx] = '0;
         end else if (cnt_q[idx] == DEB_MAX) begin
            stab_d[idx] = s1_key_q;
            cnt_d[idx]  = '0;
            push        = 1'b1;
         end else begin
            cnt_d[idx] = cnt_q[idx] + 4'd1;
         end
      end
   end

   // Per-key stable level and disagreement counters
   always_ff @(posedge clk_50) begin
      if (rst) begin
         stab_q <= '0;
         cnt_q  <= '{default: '0};
      end else begin
         stab_q <= stab_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef KEY_TIMESTAMP_EN
   logic [15:0] ts_q;

   // Count in-range samples; an event carries the count before its own sample
   always_ff @(posedge clk_50) begin
      if (rst) begin
         ts_q <= '0;
      end else if (in_rng) begin
         ts_q <= ts_q + 16'd1;
      end
   end

   assign ev_new = {ts_q, s1_key_q, 2'b00, idx};
`else
   assign ev_new = {s1_key_q, 2'b00, idx};
`endif

   assign ev_valid = (occ_q != '0);
   assign pop      = ev_valid && ev_ready;
   assign full     = (occ_q == FULL_C);
   assign push_ok  = push && (!full || pop);

   // Event storage; contents are don't-care until written
   always_ff @(posedge clk_50) begin
      if (push_ok) begin
         mem_q[wr_q] <= ev_new;
      end
   end

   // FIFO pointers, occupancy and sticky drop flag
   always_ff @(posedge clk_50) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
         if (push && !push_ok) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign ev_data   = ev_valid ? mem_q[rd_q] : '0;
   assign key_state = 32'(stab_q);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed cases plus random samples
// against a queue-based reference model with a decoupled monitor.
`timescale 1ns/1ps
module tb_key_event_encoder;

   localparam int ROWS  = 4;
   localparam int COLS  = 5;
   localparam int DEB   = 4;
   localparam int DEPTH = 8;
`ifdef KEY_TIMESTAMP_EN
   localparam int EW = 24;
`else
   localparam int EW = 8;
`endif

   logic          clk_50    = 1'b0;
   logic          rst       = 1'b1;
   logic          scan_tick = 1'b0;
   logic [2:0]    row_idx   = '0;
   logic [2:0]    col_idx   = '0;
   logic          key_down  = 1'b0;
   logic          ev_valid;
   logic          ev_ready  = 1'b0;
   logic [EW-1:0] ev_data;
   logic [31:0]   key_state;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk_50 = ~clk_50;

   key_event_encoder #(
      .ROWS(ROWS), .COLS(COLS),
      .DEB_COUNT(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_50(clk_50), .rst(rst),
      .scan_tick(scan_tick),
      .row_idx(row_idx), .col_idx(col_idx),
      .key_down(key_down),
      .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_data(ev_data), .key_state(key_state),
      .overflow(overflow)
   );

   // Reference model state
   logic [EW-1:0] exp_q[$];
   int        mc;
   bit [31:0] m_state;
   int        run[32];
   bit        m_ovf;
   bit [15:0] m_ts;
   bit        m_vld;
   int        m_r;
   int        m_c;
   bit        m_d;
   bit        mon_en = 1'b0;

   // Model: a sample reaches the key one edge after capture;
   // DEB consecutive disagreeing samples flip the key.
   always @(posedge clk_50) begin
      bit pop;
      int k;
      if (rst) begin
         exp_q.delete();
         mc = 0;
         m_state = '0;
         foreach (run[i]) run[i] = 0;
         m_ovf = 1'b0;
         m_ts = '0;
         m_vld = 1'b0;
      end else begin
         pop = (mc > 0) && ev_ready;
         if (m_vld && m_r < ROWS && m_c < COLS) begin
            k = m_r * COLS + m_c;
            if (m_d == m_state[k]) begin
               run[k] = 0;
            end else begin
               run[k]++;
               if (run[k] == DEB) begin
                  run[k] = 0;
                  m_state[k] = m_d;
                  if (mc < DEPTH || pop) begin
                     exp_q.push_back(EW'({m_ts, m_d, 2'b00, 5'(k)}));
                     mc++;
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
            end
            m_ts++;
         end
         if (pop) mc--;
         m_vld = scan_tick;
         m_r   = int'(row_idx);
         m_c   = int'(col_idx);
         m_d   = key_down;
      end
   end

   // Monitor: compare outputs mid-cycle; pop scoreboard on handshake
   always @(negedge clk_50) begin
      logic [EW-1:0] e;
      if (mon_en) begin
         checks++;
         if (ev_valid !== (mc != 0)) begin
            errors++;
            $display("FAIL ev_valid: got %b expected %b", ev_valid, mc != 0);
         end
         checks++;
         if (key_state !== m_state) begin
            errors++;
            $display("FAIL key_state: got %h expected %h", key_state, m_state);
         end
         checks++;
         if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
         end
         if (ev_valid === 1'b1 && ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ev_data: got %h expected no event", ev_data);
            end else begin
               e = exp_q.pop_front();
               if (ev_data !== e) begin
                  errors++;
                  $display("FAIL ev_data: got %h expected %h", ev_data, e);
               end
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(int r, int c, bit d);
      scan_tick = 1'b1;
      row_idx   = 3'(r);
      col_idx   = 3'(c);
      key_down  = d;
      @(posedge clk_50); #1;
      scan_tick = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk_50); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk_50); #1;
      rst = 1'b0;
   endtask

   task automatic press(int k);
      repeat (DEB) tick(k / COLS, k % COLS, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      ev_ready = 1'b1;
      while (mc != 0 && n < 200) begin
         @(posedge clk_50); #1;
         n++;
      end
      ev_ready = 1'b0;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      int r;
      int c;
      int k;
      bit [63:0] lvl;
      logic [EW-1:0] e;

      repeat (2) @(posedge clk_50);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      chk("reset_valid", 32'(ev_valid), 32'd0);
      chk("reset_state", key_state, 32'd0);

      // single press: event 0x87 two cycles after the 4th tick
      repeat (4) tick(1, 2, 1'b1);
      chk("lat_early", 32'(ev_valid), 32'd0);
      idle(1);
      e = EW'(24'h000387);
      chk("lat_valid", 32'(ev_valid), 32'd1);
      chk("press_data", 32'(ev_data), 32'(e));
      chk("press_state", 32'(key_state[7]), 32'd1);
      drain();

      // bounce: agreeing sample clears the count
      do_reset();
      repeat (3) tick(1, 2, 1'b1);
      tick(1, 2, 1'b0);
      repeat (3) tick(1, 2, 1'b1);
      idle(2);
      chk("bounce_state", 32'(key_state[7]), 32'd0);
      chk("bounce_valid", 32'(ev_valid), 32'd0);

      // out-of-range rows and columns are ignored
      repeat (10) tick(5, 2, 1'b1);
      repeat (5) tick(1, 5, 1'b1);
      idle(2);
      chk("oor_state", key_state, 32'd0);
      chk("oor_valid", 32'(ev_valid), 32'd0);

      // nine presses into a full FIFO: the ninth is dropped
      do_reset();
      for (int i = 0; i < 9; i++) press(i);
      idle(2);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_state", key_state, 32'h1FF);
      drain();

      // push and pop together while full: no drop
      do_reset();
      for (int i = 0; i < 8; i++) press(i);
      repeat (DEB) tick(1, 3, 1'b1);
      ev_ready = 1'b1;
      idle(1);
      ev_ready = 1'b0;
      idle(1);
      chk("full_pp_ovf", 32'(overflow), 32'd0);
      ev_ready = 1'b1;
      n = 0;
      while (ev_valid && n < 20) begin
         @(posedge clk_50); #1;
         n++;
      end
      ev_ready = 1'b0;
      chk("full_pp_occ", 32'(n), 32'd8);

      // reset with events queued, then timestamp restarts at zero
      do_reset();
      press(0);
      press(1);
      press(2);
      idle(2);
      chk("pre_rst_valid", 32'(ev_valid), 32'd1);
      do_reset();
      chk("post_rst_valid", 32'(ev_valid), 32'd0);
      chk("post_rst_state", key_state, 32'd0);
      repeat (DEB) tick(0, 3, 1'b1);
      idle(1);
      e = EW'(24'h000383);
      chk("post_rst_event", 32'(ev_data), 32'(e));
      drain();

      // random noisy keys with random back-pressure
      do_reset();
      lvl = '0;
      for (int i = 0; i < 3000; i++) begin
         if ((i / 150) % 3 == 0) ev_ready = 1'b0;
         else ev_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 5);
            c = $urandom_range(0, 5);
            if (r == 2 || r == 3) r = 0;
            k = r * 8 + c;
            if ($urandom_range(0, 7) == 0) lvl[k] = ~lvl[k];
            scan_tick = 1'b1;
            row_idx   = 3'(r);
            col_idx   = 3'(c);
            key_down  = lvl[k] ^ ($urandom_range(0, 7) == 0);
         end else begin
            scan_tick = 1'b0;
         end
         @(posedge clk_50); #1;
      end
      scan_tick = 1'b0;
      idle(3);
      drain();
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
